// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
//
// Shares the single 8-bit AXI-Stream TX input of the Ethernet MAC between two
// frame sources (port 0: CPU frame buffer, port 1: debug pattern generator).
// One source owns the output for a whole frame, so bytes of different frames
// never interleave. The output stream passes through one register stage. After
// every frame the arbiter holds an idle gap before it arbitrates again.
//
// Optional feature: define ETH_TX_PAD_EN to pad short frames with 0x00 bytes
// up to MIN_LEN. Without the macro, frames pass through unchanged.
//
// Parameters
//   PRIO_FIXED  0 = round-robin, 1 = port 0 wins every tie
//   IFG_CYCLES  minimum idle cycles after a frame (0 behaves as 1)
//   MIN_LEN     minimum frame length without FCS when padding is built in
//
// Ports
//   clk_mac, rst_n           MAC clock, asynchronous active-low reset
//   sN_tdata/tvalid/tlast    source N byte stream
//   sN_tready                source N byte accepted (only the owner, in SEND)
//   m_tdata/tvalid/tlast     registered stream to the MAC
//   m_tready                 MAC ready
//   grant                    one-hot owner of the current frame, 00 when idle
//   frm_cnt0/frm_cnt1        completed source frames per port (wrapping)
// ---------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60
) (
  input  logic        clk_mac,
  input  logic        rst_n,
  input  logic [7:0]  s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [7:0]  s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [1:0]  grant,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef ETH_TX_PAD_EN
    S_PAD  = 2'd2,
`endif
    S_GAP  = 2'd3
  } state_t;

  localparam int          IFG_EFF  = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
  localparam logic [15:0] IFG_LOAD = 16'(IFG_EFF);

  if (MIN_LEN < 1 || MIN_LEN > 2047) begin : g_min_len_bad
    $error("eth_tx_arbiter: MIN_LEN must lie in 1..2047");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_grant;
  logic        r_last_port;
  logic [10:0] r_bcnt;
  logic [15:0] r_gcnt;
  logic [7:0]  r_m_tdata;
  logic        r_m_tvalid;
  logic        r_m_tlast;
  logic [15:0] r_frm_cnt0;
  logic [15:0] r_frm_cnt1;

  logic        w_load;
  logic        w_sel1;
  logic [7:0]  w_src_data;
  logic        w_src_valid;
  logic        w_src_tlast;
  logic        w_xfer;
  logic        w_src_end;
  logic        w_any;
  logic        w_pick1;
  logic [10:0] w_bcnt_inc;

  // The output register can take a new byte when it is empty or being drained.
  assign w_load = ~r_m_tvalid | m_tready;

  assign w_sel1      = r_grant[1];
  assign w_src_data  = w_sel1 ? s1_tdata  : s0_tdata;
  assign w_src_valid = w_sel1 ? s1_tvalid : s0_tvalid;
  assign w_src_tlast = w_sel1 ? s1_tlast  : s0_tlast;

  assign s0_tready = (r_state == S_SEND) & r_grant[0] & w_load;
  assign s1_tready = (r_state == S_SEND) & r_grant[1] & w_load;

  assign w_xfer     = (r_state == S_SEND) & w_load & w_src_valid;
  assign w_src_end  = w_xfer & w_src_tlast;
  assign w_bcnt_inc = (r_bcnt == 11'h7FF) ? r_bcnt : r_bcnt + 11'd1;

  // Port 1 wins when it is the only requester, or on a round-robin tie when
  // port 0 was served last.
  assign w_any   = s0_tvalid | s1_tvalid;
  assign w_pick1 = s1_tvalid & (~s0_tvalid | ((PRIO_FIXED == 0) & ~r_last_port));

`ifdef ETH_TX_PAD_EN
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  logic w_short;
  logic w_pad_emit;
  logic w_pad_last;
  // The byte being accepted brings the count to bcnt+1.
  assign w_short    = ({1'b0, r_bcnt} + 12'd1) < MIN_LEN_W;
  assign w_pad_emit = (r_state == S_PAD) & w_load;
  assign w_pad_last = w_pad_emit & (({1'b0, r_bcnt} + 12'd1) == MIN_LEN_W);
`endif

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_src_end) begin
`ifdef ETH_TX_PAD_EN
          w_state_nxt = w_short ? S_PAD : S_GAP;
`else
          w_state_nxt = S_GAP;
`endif
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD:  if (w_pad_last) w_state_nxt = S_GAP;
`endif
      // Leave only once the gap is counted and the final byte has drained.
      S_GAP:  if (r_gcnt == 16'd0 && !r_m_tvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= 2'b00;
      r_last_port <= 1'b1;
      r_bcnt      <= 11'd0;
      r_gcnt      <= 16'd0;
      r_m_tdata   <= 8'h00;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_frm_cnt0  <= 16'd0;
      r_frm_cnt1  <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (r_state == S_IDLE && w_any) begin
        r_grant <= {w_pick1, ~w_pick1};
        r_bcnt  <= 11'd0;
      end

      if (w_state_nxt == S_GAP && r_state != S_GAP) begin
        r_grant <= 2'b00;
        r_gcnt  <= IFG_LOAD;
      end else if (r_state == S_GAP && r_gcnt != 16'd0) begin
        r_gcnt <= r_gcnt - 16'd1;
      end

      if (w_xfer) begin
        r_m_tdata  <= w_src_data;
        r_m_tvalid <= 1'b1;
`ifdef ETH_TX_PAD_EN
        r_m_tlast  <= w_src_tlast & ~w_short;
`else
        r_m_tlast  <= w_src_tlast;
`endif
        r_bcnt     <= w_bcnt_inc;
`ifdef ETH_TX_PAD_EN
      end else if (w_pad_emit) begin
        r_m_tdata  <= 8'h00;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= w_pad_last;
        r_bcnt     <= w_bcnt_inc;
`endif
      end else if (w_load) begin
        r_m_tvalid <= 1'b0;
      end

      if (w_src_end) begin
        r_last_port <= w_sel1;
        if (w_sel1) r_frm_cnt1 <= r_frm_cnt1 + 16'd1;
        else        r_frm_cnt0 <= r_frm_cnt0 + 16'd1;
      end
    end
  end

  assign m_tdata  = r_m_tdata;
  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign grant    = r_grant;
  assign frm_cnt0 = r_frm_cnt0;
  assign frm_cnt1 = r_frm_cnt1;

endmodule
